request_conditioner: RTL

REQUEST_CONDITIONER -- requirements
Module: request_conditioner

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/request_conditioner_if.sv | 39 +++
 rtl/debounce.sv | 59 +++++
 rtl/request_conditioner.sv | 83 ++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller family: light encodings,
// default timing parameters and a constant-width helper.
package traffic_pkg;

    // One-hot light encodings used by the light controller.
    typedef enum logic [2:0] {
        RED    = 3'b001,
        YELLOW = 3'b010,
        GREEN  = 3'b100
    } light_t;

    // Fast clock cycles per one-second tick at the board clock rate.
    localparam int DEFAULT_TICK_DIV        = 37500000;
    // Roughly 27 ms of contact bounce rejection at the board clock rate.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Ceiling log2, never less than 1 so that counters always have a bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/request_conditioner_if.sv
// Signals between the raw pedestrian/vehicle inputs, the request conditioner
// and the light controller.
//
// walk_request / walk_ack form a request/acknowledge pair: walk_request rises
// on a new debounced press and is held; the controller pulses walk_ack for one
// cycle when it has served the request, and walk_request drops on the next
// cycle unless a new press arrives in that same cycle. sensor_request is a
// plain level, and sec_tick is a one-cycle enable with no handshake.
interface request_conditioner_if;
    logic walk_button;
    logic side_sensor;
    logic walk_ack;
    logic walk_request;
    logic sensor_request;
    logic sec_tick;
    logic led_clock;

    // Controller / environment side.
    modport master (
        output walk_button,
        output side_sensor,
        output walk_ack,
        input  walk_request,
        input  sensor_request,
        input  sec_tick,
        input  led_clock
    );

    // Request conditioner side.
    modport slave (
        input  walk_button,
        input  side_sensor,
        input  walk_ack,
        output walk_request,
        output sensor_request,
        output sec_tick,
        output led_clock
    );
endinterface

// File: rtl/debounce.sv
// Two-flop synchronizer followed by an optional run-length debouncer.
// Build option: define TRAFFIC_DEBOUNCE_EN to insert the debouncer; without it
// the level output is the synchronizer output and DEBOUNCE_CYCLES is ignored.
module debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic fast_clock,
    input  logic reset,
    input  logic raw_in,
    output logic level
);

    logic sync_meta;
    logic sync_out;

    // Bring the asynchronous input into the fast_clock domain.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw_in;
            sync_out  <= sync_meta;
        end
    end

`ifdef TRAFFIC_DEBOUNCE_EN
    localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] run_count;
    logic             stable;

    // Accept a new level only after it has differed from the stable value for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the run.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            stable    <= 1'b0;
            run_count <= '0;
        end else if (sync_out == stable) begin
            run_count <= '0;
        end else if (run_count == CNT_LAST) begin
            stable    <= sync_out;
            run_count <= '0;
        end else begin
            run_count <= run_count + CNT_W'(1);
        end
    end

    assign level = stable;
`else
    localparam int debounce_cycles_unused = DEBOUNCE_CYCLES;

    assign level = sync_out;
`endif

endmodule

// File: rtl/request_conditioner.sv
// Conditions the raw pedestrian button and side-street sensor for the light
// controller and generates its one-second time base and a blinking LED clock.
// Build option: TRAFFIC_DEBOUNCE_EN enables the debouncers inside debounce.
module request_conditioner
    import traffic_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                   fast_clock,
    input  logic                   reset,
    request_conditioner_if.slave   bus
);

    localparam int TICK_W = clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic walk_level;
    logic side_level;
    logic walk_level_d;
    logic walk_rise;
    logic walk_request_q;
    logic sensor_request_q;

    logic [TICK_W-1:0] tick_count;
    logic              tick_hit;
    logic              led_q;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) walk_deb (
        .fast_clock (fast_clock),
        .reset      (reset),
        .raw_in     (bus.walk_button),
        .level      (walk_level)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) side_deb (
        .fast_clock (fast_clock),
        .reset      (reset),
        .raw_in     (bus.side_sensor),
        .level      (side_level)
    );

    // A press is the rising edge of the debounced level, so a held button
    // cannot re-arm the request.
    assign walk_rise = walk_level & ~walk_level_d;

    // Latch walk presses until acknowledged (a simultaneous press wins) and
    // register the sensor level.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            walk_level_d     <= 1'b0;
            walk_request_q   <= 1'b0;
            sensor_request_q <= 1'b0;
        end else begin
            walk_level_d     <= walk_level;
            sensor_request_q <= side_level;
            if (walk_rise) begin
                walk_request_q <= 1'b1;
            end else if (bus.walk_ack) begin
                walk_request_q <= 1'b0;
            end
        end
    end

    assign tick_hit = (tick_count == TICK_LAST);

    // Free-running 0..TICK_DIV-1 counter and LED toggle one cycle after each tick.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            tick_count <= '0;
            led_q      <= 1'b0;
        end else begin
            tick_count <= tick_hit ? '0 : tick_count + TICK_W'(1);
            led_q      <= led_q ^ tick_hit;
        end
    end

    assign bus.walk_request   = walk_request_q;
    assign bus.sensor_request = sensor_request_q;
    assign bus.sec_tick       = tick_hit;
    assign bus.led_clock      = led_q;

endmodule
